// File: rtl/ysyx_22041207_if_id_queue_if.sv
// Handshake bundle between the IF stage, the IF/ID instruction queue and the ID stage.
// slave  : the queue itself (consumes if_*, produces id_* and flow-control outputs)
// master : the surrounding pipeline (produces if_*, id_ready and flush)
interface ysyx_22041207_if_id_queue_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int CNT_W  = 2
);
  // IF -> queue
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              pc_delay;
  // queue -> ID
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_ready;
  // EX redirect and occupancy
  logic              flush;
  logic [CNT_W-1:0]  count;

  modport master (
    output if_valid, if_pc, if_inst, id_ready, flush,
    input  if_ready, pc_delay, id_valid, id_pc, id_inst, count
  );

  modport slave (
    input  if_valid, if_pc, if_inst, id_ready, flush,
    output if_ready, pc_delay, id_valid, id_pc, id_inst, count
  );
endinterface

// File: rtl/ysyx_22041207_if_id_queue.sv
// IF/ID instruction queue for the ysyx_22041207 RV64 core.
// Circular buffer of {pc, inst} pairs with valid/ready handshakes on both sides,
// a full-driven pc_delay back to IF and a single-cycle flush on EX redirect.
// Optional feature macro: YSYX_22041207_IFQ_BYPASS_EN
//   When defined, an instruction arriving at an empty queue is shown to ID in the
//   same cycle and is not written if ID takes it immediately.
//   When undefined, id_* depend only on registered state (minimum latency 1 cycle).
module ysyx_22041207_if_id_queue #(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic clk,
  input  logic rst,
  ysyx_22041207_if_id_queue_if.slave io_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];

  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic [PW-1:0]     w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_if_ready;
  logic              w_bypass;
  logic              w_id_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DEPTH-1:0]  w_entry_we;
  logic [PC_W-1:0]   w_id_pc;
  logic [INST_W-1:0] w_id_inst;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

  // Readiness comes from registered occupancy only: a same-cycle pop never frees
  // a slot for a push, which keeps id_ready off the if_ready timing path.
  assign w_if_ready = ~w_full;

`ifdef YSYX_22041207_IFQ_BYPASS_EN
  assign w_bypass = w_empty & io_bus.if_valid & ~io_bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_id_valid = ~w_empty | w_bypass;

  // Flush wins over both sides of the handshake in the same cycle.
  assign w_push = io_bus.if_valid & w_if_ready & ~io_bus.flush;
  assign w_pop  = w_id_valid & io_bus.id_ready & ~io_bus.flush;

  // A bypassed instruction taken by ID this cycle never touches storage.
  assign w_wr_en = w_push & ~(w_bypass & io_bus.id_ready);
  assign w_rd_en = w_pop & ~w_empty;

  // One write-enable per entry, decoded from the write index.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign w_entry_we[gi] = w_wr_en & (w_wr_idx == AW'(gi));
    end
  endgenerate

  // Pointer update: flush and reset both return the queue to empty at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (io_bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Entry storage: contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_we[i]) begin
        r_pc_mem[i]   <= io_bus.if_pc;
        r_inst_mem[i] <= io_bus.if_inst;
      end
    end
  end

  // Head selection: stored head, bypassed fetch, or the idle pattern (pc 0, NOP).
  always_comb begin
    w_id_pc   = '0;
    w_id_inst = NOP_INST;
    if (!w_empty) begin
      w_id_pc   = r_pc_mem[w_rd_idx];
      w_id_inst = r_inst_mem[w_rd_idx];
    end else if (w_bypass) begin
      w_id_pc   = io_bus.if_pc;
      w_id_inst = io_bus.if_inst;
    end
  end

  assign io_bus.if_ready = w_if_ready;
  assign io_bus.pc_delay = ~w_if_ready;
  assign io_bus.id_valid = w_id_valid;
  assign io_bus.id_pc    = w_id_pc;
  assign io_bus.id_inst  = w_id_inst;
  assign io_bus.count    = w_count;

endmodule

// File: tb/tb_ysyx_22041207_if_id_queue.sv
// Self-checking bench for the IF/ID instruction queue (DEPTH=2).
// A queue-of-entries model predicts every output each cycle; directed steps add
// hand-computed literal checks. Honours YSYX_22041207_IFQ_BYPASS_EN if defined.
module tb_ysyx_22041207_if_id_queue;
  localparam int DEPTH  = 2;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;
`ifdef YSYX_22041207_IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] NOP = 64'h13;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ysyx_22041207_if_id_queue_if #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CW)) bus ();

  ysyx_22041207_if_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  ent_t mq[$];
  logic [63:0] seen[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
    bus.id_ready = rdy;
    bus.flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model compare and update, mid-cycle when inputs and outputs are stable.
  always @(negedge clk) begin : cmp
    int          sz;
    logic        byp_now, e_valid, e_ready, pop, push;
    logic [63:0] e_pc, e_inst;
    ent_t        e;
    if (rst) begin
      mq.delete();
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
      chk("rst_id_pc", bus.id_pc, 64'd0);
      chk("rst_id_inst", 64'(bus.id_inst), NOP);
      chk("rst_if_ready", 64'(bus.if_ready), 64'd1);
      chk("rst_pc_delay", 64'(bus.pc_delay), 64'd0);
    end else begin
      sz      = mq.size();
      byp_now = BYP && (sz == 0) && bus.if_valid && !bus.flush;
      e_valid = (sz != 0) || byp_now;
      e_ready = (sz != DEPTH);
      e_pc    = 64'd0;
      e_inst  = NOP;
      if (sz != 0) begin
        e_pc   = mq[0].pc;
        e_inst = 64'(mq[0].inst);
      end else if (byp_now) begin
        e_pc   = bus.if_pc;
        e_inst = 64'(bus.if_inst);
      end
      chk("count", 64'(bus.count), 64'(sz));
      chk("id_valid", 64'(bus.id_valid), 64'(e_valid));
      chk("id_pc", bus.id_pc, e_pc);
      chk("id_inst", 64'(bus.id_inst), e_inst);
      chk("if_ready", 64'(bus.if_ready), 64'(e_ready));
      chk("pc_delay", 64'(bus.pc_delay), 64'(!e_ready));
      if (bus.id_valid && bus.id_ready && !bus.flush) seen.push_back(bus.id_pc);
      if (bus.flush) begin
        mq.delete();
      end else begin
        pop  = e_valid && bus.id_ready;
        push = bus.if_valid && e_ready;
        if (!(byp_now && pop)) begin
          if (pop) void'(mq.pop_front());
          if (push) begin
            e.pc   = bus.if_pc;
            e.inst = bus.if_inst;
            mq.push_back(e);
          end
        end
      end
    end
  end

  // Directed stimulus with literal expectations.
  initial begin : stim
    int idx;
    int hits;
    bit acc;
    bit done;
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    #2;
    chk("init_count", 64'(bus.count), 64'd0);
    chk("init_id_inst", 64'(bus.id_inst), NOP);
    chk("init_if_ready", 64'(bus.if_ready), 64'd1);
    rst = 1'b0;
    tick();

    // Fill to full with ID stalled.
    drive(1'b1, 64'h8000_0000, 32'h0000_0093, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("full_count", 64'(bus.count), 64'd2);
    chk("full_if_ready", 64'(bus.if_ready), 64'd0);
    chk("full_pc_delay", 64'(bus.pc_delay), 64'd1);
    chk("full_id_pc", bus.id_pc, 64'h8000_0000);

    // Full: pop and attempted push in the same cycle; push must be rejected.
    drive(1'b1, 64'h8000_0008, 32'h0020_0093, 1'b1, 1'b0);
    tick();
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("popfull_count", 64'(bus.count), 64'd1);
    chk("popfull_id_pc", bus.id_pc, 64'h8000_0004);
    chk("popfull_id_inst", 64'(bus.id_inst), 64'h0010_0093);

    // Asynchronous reset with two entries queued.
    drive(1'b1, 64'h8000_000c, 32'h0030_0093, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("prerst_count", 64'(bus.count), 64'd2);
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_id_valid", 64'(bus.id_valid), 64'd0);
    chk("arst_id_inst", 64'(bus.id_inst), NOP);
    chk("arst_if_ready", 64'(bus.if_ready), 64'd1);
    chk("arst_id_pc", bus.id_pc, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Stream 10 sequential pcs with id_ready toggling 1,0,1,0...
    seen.delete();
    idx  = 0;
    done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (idx < 10)
        drive(1'b1, 64'h8000_1000 + 64'(4 * idx), 32'h0000_0093 | (32'(idx) << 20),
              (c % 2) == 0, 1'b0);
      else
        drive(1'b0, 64'd0, 32'd0, (c % 2) == 0, 1'b0);
      #2;
      acc = bus.if_valid && bus.if_ready;
      tick();
      if (acc) idx++;
      if (idx == 10 && seen.size() == 10) done = 1'b1;
    end
    chk("stream_done", 64'(done), 64'd1);
    chk("stream_seen_n", 64'(seen.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stream_order_%0d", i),
          (i < seen.size()) ? seen[i] : 64'hffff_ffff_ffff_ffff,
          64'h8000_1000 + 64'(4 * i));
    end
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // Flush with two entries queued and a simultaneous push.
    seen.delete();
    drive(1'b1, 64'h8000_0200, 32'h0060_0093, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h8000_0204, 32'h0070_0093, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h8000_0100, 32'h0100_0093, 1'b1, 1'b1);
    #2;
    chk("preflush_count", 64'(bus.count), 64'd2);
    tick();
    drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    #2;
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_id_valid", 64'(bus.id_valid), 64'd0);
    // Flush on an empty queue with a push offered: still dropped.
    drive(1'b1, 64'h8000_0100, 32'h0100_0093, 1'b1, 1'b1);
    #2;
    chk("flush_empty_if_ready", 64'(bus.if_ready), 64'd1);
    chk("flush_empty_id_valid", 64'(bus.id_valid), 64'd0);
    tick();
    drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    #2;
    chk("flush2_count", 64'(bus.count), 64'd0);
    tick();
    tick();
    hits = 0;
    for (int i = 0; i < seen.size(); i++)
      if (seen[i] == 64'h8000_0100) hits++;
    chk("flush_dropped_pc_seen", 64'(hits), 64'd0);

    // Push into empty queue with ID ready: same-cycle with bypass, else next cycle.
    drive(1'b1, 64'h8000_0010, 32'h0050_0093, 1'b1, 1'b0);
    #2;
    chk("byp_id_valid_now", 64'(bus.id_valid), BYP ? 64'd1 : 64'd0);
    chk("byp_id_pc_now", bus.id_pc, BYP ? 64'h8000_0010 : 64'd0);
    tick();
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("byp_count_next", 64'(bus.count), BYP ? 64'd0 : 64'd1);
    chk("byp_id_valid_next", 64'(bus.id_valid), BYP ? 64'd0 : 64'd1);
    chk("byp_id_pc_next", bus.id_pc, BYP ? 64'd0 : 64'h8000_0010);
    drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    tick();
    tick();
    #2;
    chk("final_count", 64'(bus.count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
